// File: rtl/ana_pad_pkg.sv
// Shared definitions for the analog pad arbiter and its round-robin picker:
// state encoding, default timing constants and the requester-ID width helper.
package ana_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAKE  = 2'd1,
        OWNED = 2'd2,
        BREAK = 2'd3
    } pad_state_t;

    localparam int DEF_N_REQ         = 4;
    localparam int DEF_BBM_CYCLES    = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_MAX_HOLD      = 0;
    localparam int DEF_CNT_W         = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ana_rr_pick.sv
// Combinational round-robin picker: searches req upward from ptr with
// wrap-around and returns the first hit as one-hot, as an index, and an
// any-request flag. Shared with the digital pad-mux controller.
module ana_rr_pick
    import ana_pad_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [id_w(N_REQ)-1:0]  ptr,
    output logic [N_REQ-1:0]        gnt,
    output logic [id_w(N_REQ)-1:0]  idx,
    output logic                    any
);

    localparam int IDW = id_w(N_REQ);

    // First requester at or above the pointer, wrapping past N_REQ-1 to 0.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int s;
            int k;
            s = int'(ptr) + i;
            k = (s >= N_REQ) ? (s - N_REQ) : s;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/ana_pad_arbiter.sv
// Arbiter for one shared analog pad. Closes at most one transmission gate at
// a time, waits a settle delay before flagging the owner ready, and keeps
// every switch open for a break-before-make gap between owners. force_open
// opens everything immediately and holds the gap while it stays high.
module ana_pad_arbiter
    import ana_pad_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int BBM_CYCLES    = DEF_BBM_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_HOLD      = DEF_MAX_HOLD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic                    force_open,
    output logic [N_REQ-1:0]        sw_en,
    output logic [N_REQ-1:0]        ready,
    output logic [id_w(N_REQ)-1:0]  owner_id,
    output logic                    busy
);

    localparam int IDW = id_w(N_REQ);

    localparam logic [CNT_W-1:0] BBM_RELOAD    = CNT_W'(BBM_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(MAX_HOLD - 1);

    pad_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDW-1:0]   ptr;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    logic             owner_req;
    logic             others;
    logic             hold_hit;
    logic             release_now;
    logic [IDW-1:0]   next_ptr;

    ana_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Release decision: owner dropped its request, or it has hogged the pad
    // for MAX_HOLD cycles while someone else was waiting.
    always_comb begin
        owner_req   = req[owner_id];
        others      = |(req & ~sw_en);
        hold_hit    = (MAX_HOLD != 0) && (state == OWNED) && others &&
                      (hold_cnt == HOLD_LAST);
        release_now = ((state == MAKE) || (state == OWNED)) &&
                      (!owner_req || hold_hit);
        next_ptr    = (owner_id == IDW'(N_REQ - 1)) ? '0 : owner_id + IDW'(1);
    end

    // Pad ownership FSM with registered switch, ready, owner and busy outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sw_en    <= '0;
            ready    <= '0;
            owner_id <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            hold_cnt <= '0;
        end else if (force_open) begin
            // Reload every cycle so the gap only starts counting once it drops.
            state <= BREAK;
            sw_en <= '0;
            ready <= '0;
            busy  <= 1'b1;
            cnt   <= BBM_RELOAD;
        end else if (release_now) begin
            state <= BREAK;
            sw_en <= '0;
            ready <= '0;
            busy  <= 1'b1;
            cnt   <= BBM_RELOAD;
            ptr   <= next_ptr;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= MAKE;
                        sw_en    <= pick_gnt;
                        owner_id <= pick_idx;
                        cnt      <= SETTLE_RELOAD;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                MAKE: begin
                    if (cnt == '0) begin
                        state <= OWNED;
                        ready <= sw_en;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                OWNED: begin
                    if ((MAX_HOLD != 0) && others) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ana_pad_arbiter.md
Name: ana_pad_arbiter

Overview:
- Shares one analog bidirectional pad (APRIO-class, unbuffered Z node) between N_REQ on-chip analog requesters, e.g. ADC inputs, DAC outputs and the analog test bus.
- Drives one-hot enables for the per-requester transmission gates between each requester and the pad's Z node.
- Enforces break-before-make dead time and a settle delay before a requester may use the pad.
- Sits in the digital core next to the pad ring; one instance per shared analog pad.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- BBM_CYCLES, 4, cycles all switches stay open after a release (>=1)
- SETTLE_CYCLES, 16, cycles from switch close to ready (>=1)
- MAX_HOLD, 0, maximum OWNED cycles while others are pending; 0 = no limit
- CNT_W, 8, width of the dead-time/settle/hold counters; must hold max(BBM_CYCLES, SETTLE_CYCLES, MAX_HOLD)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- req  in  N_REQ  level request per requester; held while the pad is wanted
- force_open  in  1  test/ESD mode; opens all switches
- sw_en  out  N_REQ  one-hot transmission-gate enables
- ready  out  N_REQ  one-hot; owner may drive or sample the pad
- owner_id  out  $clog2(N_REQ)  index of current or last owner
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clk is the single clock; reset is rst_n, synchronous and active-low. On reset, sw_en=0, ready=0, owner_id=0, busy=0, state=IDLE, round-robin pointer=0, all counters=0.
- All outputs are registered. States are IDLE, MAKE, OWNED and BREAK.
- IDLE: if any req bit is high, pick the winner round-robin, searching upward from the pointer with wrap-around. On the next edge:
  - sw_en[winner]=1
  - owner_id=winner
  - counter loads SETTLE_CYCLES-1
  - state goes to MAKE
- MAKE: counter decrements each cycle.
  - At 0: ready[owner]=1 and state goes to OWNED.
  - Latency: req sampled at edge E gives sw_en at E+1 and ready at E+1+SETTLE_CYCLES.
- OWNED: held while req[owner]=1. Other requests wait; there is no preemption except MAX_HOLD.
- Release, from MAKE or OWNED, when req[owner]=0 (abort inside MAKE is allowed). On the next edge:
  - sw_en=0, ready=0
  - counter loads BBM_CYCLES-1
  - pointer becomes (owner+1) mod N_REQ
  - state goes to BREAK
- MAX_HOLD (nonzero only): a hold counter counts OWNED cycles while any other req bit is high. On reaching MAX_HOLD, the block performs the release sequence even though req[owner] is still 1. The pointer advance lets the others win next.
- BREAK: counter decrements; at 0 the state goes to IDLE.
  - All switches stay open for BBM_CYCLES+1 cycles (BREAK plus the IDLE arbitration cycle) between any two closures.
  - No two sw_en bits are ever high together, and no sw_en transitions directly from one bit to another.
- force_open has the highest priority, from any state. On the next edge sw_en=0, ready=0, counter loads BBM_CYCLES-1 and state goes to BREAK. The counter is held at reload while force_open=1. The normal BREAK countdown resumes after it drops.
- Simultaneous release and new request in the same cycle: the new request is handled only after BREAK completes.
- A req bit that drops before being granted needs no action; pulses are not latched.
- Reset mid-operation: the next edge opens all switches immediately. The analog side tolerates the missing dead time.
- Invariants:
  - ready is always a subset of sw_en.
  - owner_id is stable while sw_en≠0.
  - owner_id updates only on entry to MAKE.

Decomposition:
- Shared package ana_pad_pkg holds:
  - state encoding constants (IDLE=2'd0, MAKE=2'd1, OWNED=2'd2, BREAK=2'd3)
  - a width helper for the ID
  - the default timing constants
- Sub-module ana_rr_pick: combinational round-robin picker. Inputs are req and the pointer; outputs are a one-hot grant, the index and an any-request flag. It is reusable by the digital pad-mux controller.

Test Plan:
- Single request, defaults: req=4'b0010 held from edge 10 → sw_en=0010 at edge 11, ready=0010 at edge 27, owner_id=1, busy=1.
- Handover: req=0011 with owner 0 in OWNED; drop req[0] at edge T → sw_en=0 from T+1 to T+5, sw_en=0010 at T+6; no overlap checked every cycle.
- Round-robin fairness: all four req held and each owner releases after 30 cycles → grant order 0,1,2,3,0.
- Abort in MAKE: req[2] drops 5 cycles after sw_en rises → ready never asserts; BREAK lasts 4 cycles; busy=0 afterwards.
- MAX_HOLD=50: owner 0 holds req while req[3]=1 → ready[0] drops after 50 OWNED cycles; owner 3 gets sw_en 5 cycles later; req[0] is re-granted only after owner 3 releases.
- force_open and reset: assert force_open in OWNED → all outputs 0 next edge and stay 0 while high, regrant BBM_CYCLES+1 cycles after release; rst_n=0 in MAKE → all outputs 0 next edge, pointer=0.
